// File: rtl/bm_sched_pkg.sv
// Shared types and helpers for the Bayesian-machine batch inference scheduler.
//   NUM_CLASSES / OBS_W / RES_BYTE_W : fixed geometry of the chip interface
//   obs_set_t                        : four 9-bit observation addresses {O4,O3,O2,O1}
//   sched_state_t                    : sequencer states
//   sat_add                          : saturating accumulate of one class byte
package bm_sched_pkg;

  localparam int NUM_CLASSES = 4;
  localparam int OBS_W       = 9;
  localparam int RES_BYTE_W  = 8;

  // [8:3] row, [2:0] col per element; element 0 is O1.
  typedef logic [NUM_CLASSES-1:0][OBS_W-1:0] obs_set_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    DONE
  } sched_state_t;

  // Adds one likelihood byte to an accumulator and clamps at max_val.
  // Operates on 32-bit containers so any ACC_W up to 31 can use it.
  function automatic logic [31:0] sat_add(
    input logic [31:0]           acc,
    input logic [RES_BYTE_W-1:0] inc,
    input logic [31:0]           max_val
  );
    logic [32:0] sum;
    sum = {1'b0, acc} + {25'd0, inc};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/bm_obs_fifo.sv
// Synchronous FIFO holding pending observation sets.
//   clk, rst_n  : clock, asynchronous active-low reset (discards contents)
//   push        : write push_data (ignored when full)
//   pop         : advance read pointer (ignored when empty)
//   pop_data    : head entry, valid whenever empty is low
//   full, empty : occupancy flags
module bm_obs_fifo
  import bm_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  obs_set_t push_data,
  input  logic     pop,
  output obs_set_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  obs_set_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; empty/full gate every read, so stale entries
  // are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bm_infer_scheduler.sv
// Batch inference sequencer. Buffers observation sets, issues each set to the
// chip controller NUM_RUNS times, accumulates the four per-class likelihood
// bytes with saturation and reports the argmax class and its score.
//   obs_valid/obs_ready/obs_data  : observation set input stream
//   req_valid/req_ready/req_obs   : run request to the chip controller
//   res_valid/res_data            : one-cycle result pulse, c0 in [7:0]
//   out_valid/out_ready           : decision handshake
//   out_class/out_score/out_err   : argmax, its accumulator, timeout abort flag
//   busy                          : sequencer active or sets pending
module bm_infer_scheduler
  import bm_sched_pkg::*;
#(
  parameter int NUM_RUNS   = 16,
  parameter int ACC_W      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             obs_valid,
  output logic             obs_ready,
  input  logic [35:0]      obs_data,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [35:0]      req_obs,
  input  logic             res_valid,
  input  logic [31:0]      res_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_class,
  output logic [ACC_W-1:0] out_score,
  output logic             out_err,
  output logic             busy
);

  localparam int          TO_W     = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [7:0]  RUN_LAST = 8'(NUM_RUNS - 1);
  localparam logic [31:0] ACC_MAX  = 32'hFFFF_FFFF >> (32 - ACC_W);

  sched_state_t     state;
  sched_state_t     state_nxt;

  logic             ready_q;      // holds obs_ready low until the first clock after reset
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  obs_set_t         fifo_head;

  obs_set_t         cur_obs;
  logic [ACC_W-1:0] acc     [NUM_CLASSES];
  logic [ACC_W-1:0] acc_sum [NUM_CLASSES];
  logic [ACC_W-1:0] acc_nxt [NUM_CLASSES];
  logic [7:0]       run_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             err_q;

  logic             res_take;
  logic             res_last;
  logic             timeout_hit;

  logic [1:0]       idx_lo;
  logic [1:0]       idx_hi;
  logic [1:0]       amax_idx;
  logic [ACC_W-1:0] val_lo;
  logic [ACC_W-1:0] val_hi;
  logic [ACC_W-1:0] amax_val;

  // ---------------------------------------------------------------------------
  // Observation buffer. obs_ready depends only on fullness, never on a pop in
  // the same cycle, so a full FIFO refuses the push even while draining.
  // ---------------------------------------------------------------------------
  assign obs_ready = ready_q & ~fifo_full;
  assign fifo_push = obs_valid & obs_ready;

  bm_obs_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (obs_set_t'(obs_data)),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_nxt   = state;
    fifo_pop    = 1'b0;
    res_take    = 1'b0;
    res_last    = 1'b0;
    timeout_hit = 1'b0;
    req_valid   = 1'b0;
    out_valid   = 1'b0;
    busy        = (state != IDLE) | ~fifo_empty;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        req_valid = 1'b1;
        if (req_ready) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        // A result on the last timeout cycle still counts; res_valid wins.
        if (res_valid) begin
          res_take = 1'b1;
          res_last = (run_cnt == RUN_LAST);
          state_nxt = res_last ? DONE : ISSUE;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Saturating accumulate. acc_nxt is what the accumulators hold after this
  // edge, so the argmax below already sees the final run's contribution.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      acc_sum[i] = ACC_W'(sat_add(32'(acc[i]),
                                  res_data[RES_BYTE_W*i +: RES_BYTE_W],
                                  ACC_MAX));
      acc_nxt[i] = res_take ? acc_sum[i] : acc[i];
    end
  end

  // Two-level argmax tree. Strict greater-than on the higher index means a
  // tie keeps the lower index at every level.
  always_comb begin
    idx_lo   = (acc_nxt[1] > acc_nxt[0]) ? 2'd1 : 2'd0;
    val_lo   = acc_nxt[idx_lo];
    idx_hi   = (acc_nxt[3] > acc_nxt[2]) ? 2'd3 : 2'd2;
    val_hi   = acc_nxt[idx_hi];
    amax_idx = (val_hi > val_lo) ? idx_hi : idx_lo;
    amax_val = (val_hi > val_lo) ? val_hi : val_lo;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      cur_obs   <= '0;
      run_cnt   <= '0;
      to_cnt    <= '0;
      err_q     <= 1'b0;
      out_class <= '0;
      out_score <= '0;
      out_err   <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
    end else begin
      ready_q <= 1'b1;

      if (fifo_pop) begin
        cur_obs <= fifo_head;
        run_cnt <= '0;
        err_q   <= 1'b0;
        for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
      end else if (res_take) begin
        for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= acc_sum[i];
        if (!res_last) run_cnt <= run_cnt + 1'b1;
      end

      // to_cnt counts WAIT_RES cycles since the request was accepted.
      if (state == ISSUE && req_ready) begin
        to_cnt <= '0;
      end else if (state == WAIT_RES) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (timeout_hit) err_q <= 1'b1;

      // Decision captured on DONE entry and held until the consumer takes it.
      if (state == WAIT_RES && state_nxt == DONE) begin
        out_class <= amax_idx;
        out_score <= amax_val;
        out_err   <= err_q | timeout_hit;
      end
    end
  end

  assign req_obs = cur_obs;

endmodule
